// File: rtl/uart_rx_fifo.sv
// Generic first-word-fall-through FIFO; head is read straight from the storage registers.
// Latency: a write is visible at the head 1 clock later. Backpressure: wr_rdy=0 only when full with no pop.
// Pointers wrap naturally (DEPTH is a power of 2); count spans 0..DEPTH.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_vld,
   output logic          wr_rdy,
   input  logic [W-1:0]  wr_dat,
   output logic          rd_vld,
   input  logic          rd_rdy,
   output logic [W-1:0]  rd_dat,
   output logic [AW:0]   count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop;
   logic          wr;

   assign rd_vld = (count != '0);
   assign pop    = rd_vld && rd_rdy;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign wr_rdy = (count != (AW+1)'(DEPTH)) || pop;
   assign wr     = wr_vld && wr_rdy;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// 8N1 UART receiver with oversampled start/stop validation feeding a FWFT byte FIFO.
// Latency: byte at head 1 clock after the stop-bit sample. Backpressure: full FIFO drops bytes, sets overrun.
// Error flags are sticky until clear_err; a set in the same cycle as clear_err wins.
module uart_rx_fifo #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 16,
   localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          rxd,
   output logic [7:0]    m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [CW-1:0] fifo_count,
   output logic          overrun,
   output logic          framing_err,
   input  logic          clear_err
);
   localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW      = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE/2 - 1);
   localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t        state;
   logic [DW-1:0] div_cnt;
   logic          tick;
   logic [1:0]    sync_q;
   logic          rxs;
   logic [SW-1:0] scnt;
   logic [2:0]    bcnt;
   logic [7:0]    shreg;
   logic          stop_sample;
   logic          push;
   logic          framing_set;
   logic          wr_rdy;

   assign tick = (div_cnt == DW'(DIV - 1));
   assign rxs  = sync_q[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         sync_q  <= 2'b11;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         sync_q  <= {sync_q[0], rxd};
      end
   end

   // Push is decoded straight from the stop-sample cycle so the byte lands on the next edge.
   assign stop_sample = tick && (state == S_STOP) && (scnt == S_END);
   assign push        = stop_sample && rxs;
   assign framing_set = stop_sample && !rxs;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         scnt  <= '0;
         bcnt  <= '0;
         shreg <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!rxs) begin
                  scnt  <= '0;
                  state <= S_START;
               end
            end
            S_START: begin
               if (tick) begin
                  if (scnt == S_MID) begin
                     scnt  <= '0;
                     bcnt  <= '0;
                     state <= rxs ? S_IDLE : S_DATA;
                  end else begin
                     scnt <= scnt + 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (scnt == S_END) begin
                     shreg[bcnt] <= rxs;
                     scnt        <= '0;
                     if (bcnt == 3'd7) state <= S_STOP;
                     else              bcnt  <= bcnt + 1'b1;
                  end else begin
                     scnt <= scnt + 1'b1;
                  end
               end
            end
            S_STOP: begin
               if (tick) begin
                  if (scnt == S_END) state <= rxs ? S_IDLE : S_BREAK;
                  else               scnt  <= scnt + 1'b1;
               end
            end
            S_BREAK: begin
               if (rxs) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun     <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         overrun     <= (push && !wr_rdy) || (overrun && !clear_err);
         framing_err <= framing_set || (framing_err && !clear_err);
      end
   end

   sync_fifo #(
      .W     (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_vld  (push),
      .wr_rdy  (wr_rdy),
      .wr_dat  (shreg),
      .rd_vld  (m_valid),
      .rd_rdy  (m_ready),
      .rd_dat  (m_data),
      .count   (fifo_count)
   );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames in, scoreboard of expected bytes out.
module tb_uart_rx_fifo;
   localparam int CLK_HZ  = 1_600_000;
   localparam int BAUD    = 10_000;
   localparam int OS      = 16;
   localparam int DEPTH   = 16;
   localparam int CW      = $clog2(DEPTH) + 1;
   localparam int TDIV    = 10;
   localparam int BIT_CLK = 160;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          rxd;
   logic [7:0]    m_data;
   logic          m_valid;
   logic          m_ready;
   logic [CW-1:0] fifo_count;
   logic          overrun;
   logic          framing_err;
   logic          clear_err;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            nbeats   = 0;
   int            ncyc     = 0;
   logic [7:0]    exp_q[$];

   uart_rx_fifo #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OS),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rxd         (rxd),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .fifo_count  (fifo_count),
      .overrun     (overrun),
      .framing_err (framing_err),
      .clear_err   (clear_err)
   );

   always #5 clk = ~clk;

   // Mirror of the free-running tick divider phase: tick cycles are those with ncyc%TDIV==TDIV-1.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) ncyc = 0;
      else          ncyc = ncyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && m_valid && m_ready) begin
         nbeats++;
         check("beat_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
   end

   task automatic wait_clk();
      @(posedge clk);
      #1;
   endtask

   // With pulse_push set, m_ready is raised for exactly the stop-sample cycle of this frame.
   task automatic send_byte(input logic [7:0] d, input logic stop_val, input bit pulse_push);
      logic [9:0] frame;
      int k, n1, pushn;
      frame = {stop_val, d, 1'b0};
      wait_clk();
      k  = ncyc;
      n1 = k + 3;
      while ((n1 % TDIV) != TDIV - 1) n1++;
      pushn = n1 + (OS/2 + 8*OS + OS - 1) * TDIV;
      for (int b = 0; b < 10; b++) begin
         rxd = frame[b];
         repeat (BIT_CLK) begin
            wait_clk();
            if (pulse_push) m_ready = (ncyc == pushn);
         end
      end
      rxd = 1'b1;
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      wait_clk();
      clear_err = 1'b0;
   endtask

   task automatic drain(input string tag);
      int budget;
      budget  = 200;
      m_ready = 1'b1;
      while ((exp_q.size() != 0 || m_valid) && budget > 0) begin
         wait_clk();
         budget--;
      end
      m_ready = 1'b0;
      check(tag, 32'(budget == 0), 32'd0);
   endtask

   initial begin
      int b0;
      reset_n   = 1'b0;
      rxd       = 1'b1;
      m_ready   = 1'b0;
      clear_err = 1'b0;
      repeat (5) wait_clk();
      check("rst_m_data", 32'(m_data), 32'h0);
      check("rst_m_valid", 32'(m_valid), 32'h0);
      check("rst_count", 32'(fifo_count), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      check("rst_framing", 32'(framing_err), 32'h0);
      reset_n = 1'b1;
      repeat (20) wait_clk();

      // 1: single clean byte streams straight out
      m_ready = 1'b1;
      b0 = nbeats;
      exp_q.push_back(8'h55);
      send_byte(8'h55, 1'b1, 1'b0);
      check("t1_beats", 32'(nbeats - b0), 32'd1);
      check("t1_q_empty", 32'(exp_q.size()), 32'd0);
      check("t1_framing", 32'(framing_err), 32'h0);
      check("t1_overrun", 32'(overrun), 32'h0);

      // 2: short low glitch is a false start; next frame still decodes
      b0 = nbeats;
      wait_clk();
      rxd = 1'b0;
      repeat (40) wait_clk();
      rxd = 1'b1;
      repeat (300) wait_clk();
      check("t2_beats", 32'(nbeats - b0), 32'd0);
      check("t2_count", 32'(fifo_count), 32'h0);
      check("t2_framing", 32'(framing_err), 32'h0);
      exp_q.push_back(8'h5A);
      send_byte(8'h5A, 1'b1, 1'b0);
      check("t2_after_beats", 32'(nbeats - b0), 32'd1);

      // 3: bad stop bit drops the byte and sets the sticky flag
      b0 = nbeats;
      send_byte(8'hA3, 1'b0, 1'b0);
      repeat (200) wait_clk();
      check("t3_beats", 32'(nbeats - b0), 32'd0);
      check("t3_count", 32'(fifo_count), 32'h0);
      check("t3_framing_set", 32'(framing_err), 32'h1);
      pulse_clear();
      check("t3_framing_clr", 32'(framing_err), 32'h0);

      // 4: overfill with consumer stalled
      m_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         if (i < DEPTH) exp_q.push_back(8'(i));
         send_byte(8'(i), 1'b1, 1'b0);
      end
      repeat (20) wait_clk();
      check("t4_count_full", 32'(fifo_count), 32'(DEPTH));
      check("t4_overrun", 32'(overrun), 32'h1);
      check("t4_head_hold", 32'(m_data), 32'h0);
      check("t4_valid", 32'(m_valid), 32'h1);
      drain("t4_drain_timeout");
      check("t4_count_empty", 32'(fifo_count), 32'h0);
      pulse_clear();
      check("t4_overrun_clr", 32'(overrun), 32'h0);

      // 5: reset in the middle of bit 4 discards the partial byte
      b0 = nbeats;
      begin
         logic [7:0] pd;
         pd = 8'h3C;
         wait_clk();
         rxd = 1'b0;
         repeat (BIT_CLK) wait_clk();
         for (int b = 0; b < 4; b++) begin
            rxd = pd[b];
            repeat (BIT_CLK) wait_clk();
         end
         rxd = pd[4];
         repeat (BIT_CLK/2) wait_clk();
      end
      reset_n = 1'b0;
      rxd     = 1'b1;
      repeat (5) wait_clk();
      check("t5_rst_valid", 32'(m_valid), 32'h0);
      check("t5_rst_count", 32'(fifo_count), 32'h0);
      reset_n = 1'b1;
      repeat (BIT_CLK * 2) wait_clk();
      m_ready = 1'b1;
      exp_q.push_back(8'hC3);
      send_byte(8'hC3, 1'b1, 1'b0);
      check("t5_beats", 32'(nbeats - b0), 32'd1);
      check("t5_q_empty", 32'(exp_q.size()), 32'd0);

      // 6: push into a full FIFO on the same cycle as a pop
      m_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back(8'(8'h20 + i));
         send_byte(8'(8'h20 + i), 1'b1, 1'b0);
      end
      repeat (20) wait_clk();
      check("t6_count_full", 32'(fifo_count), 32'(DEPTH));
      b0 = nbeats;
      exp_q.push_back(8'h7E);
      send_byte(8'h7E, 1'b1, 1'b1);
      m_ready = 1'b0;
      repeat (20) wait_clk();
      check("t6_one_pop", 32'(nbeats - b0), 32'd1);
      check("t6_count_same", 32'(fifo_count), 32'(DEPTH));
      check("t6_no_overrun", 32'(overrun), 32'h0);
      drain("t6_drain_timeout");
      check("t6_count_empty", 32'(fifo_count), 32'h0);
      check("t6_q_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
